// File: rtl/can_encoder.sv
// CAN 2.0A/2.0B frame transmitter: serialises a latched frame from SOF to IFS with
// bit stuffing, CRC-15 and bus readback for arbitration, bit and ACK errors.
module can_encoder #(
   parameter int EOF_BITS = 7,
   parameter int IFS_BITS = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        sample_point,
   input  logic        rx_bit,
   input  logic        tx_start,
   input  logic [10:0] field_id_a,
   input  logic        field_ide,
   input  logic [17:0] field_id_b,
   input  logic        field_rtr,
   input  logic [3:0]  field_dlc,
   input  logic [63:0] field_data,
   output logic        tx_bit,
   output logic        tx_busy,
   output logic        tx_done,
   output logic        arbitration_lost,
   output logic        bit_error,
   output logic        ack_error
);

   typedef enum logic [4:0] {
      IDLE, ARMED, SOF, ID_A, SRR, IDE, ID_B, RTR, R1, R0, DLC, DATA,
      CRC, CRC_DELIM, ACK_SLOT, ACK_DELIM, EOF, IFS
   } state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic        sp_q;
   logic [10:0] id_a;
   logic        ide;
   logic [17:0] id_b;
   logic        rtr;
   logic [3:0]  dlc;
   logic [63:0] data;
   logic [14:0] crc;
   logic [2:0]  run_len;
   logic        last_bit;
   logic        stuff_bit;

   logic        tx_edge;
   logic        rx_edge;
   logic [6:0]  data_bits;
   logic        data_last;
   logic        stuff_zone;
   logic        arb_field;
   logic        do_stuff;
   logic        frame_end;
   logic        crc_zone;
   logic        lose_arb;
   logic        ack_fail;
   logic        bit_fail;
   state_t      adv_state;
   logic [5:0]  adv_cnt;
   logic        adv_bit;

   function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
      crc_step = {c[13:0], 1'b0} ^ ((b ^ c[14]) ? 15'h4599 : 15'h0000);
   endfunction

   assign tx_edge    = sp_q & ~sample_point;
   assign rx_edge    = ~sp_q & sample_point;
   assign data_bits  = rtr ? 7'd0 : (dlc[3] ? 7'd64 : {1'b0, dlc[2:0], 3'b000});
   assign data_last  = ({1'b0, cnt} == (data_bits - 7'd1));
   assign stuff_zone = state inside {SOF, ID_A, SRR, IDE, ID_B, RTR, R1, R0, DLC, DATA, CRC};
   assign arb_field  = (state inside {ID_A, SRR, IDE, ID_B, RTR}) && !stuff_bit;
   assign do_stuff   = stuff_zone && (run_len == 3'd5);
   assign frame_end  = (state == IFS) && (cnt == 6'(IFS_BITS - 1));
   assign crc_zone   = adv_state inside {ID_A, SRR, IDE, ID_B, RTR, R1, R0, DLC, DATA};

   // Next unstuffed bit of the frame: the field, index within it and bus value
   // that follow the bit currently on the bus.
   always_comb begin
      adv_state = IDLE;
      adv_cnt   = 6'd0;
      adv_bit   = 1'b1;
      case (state)
         SOF: begin
            adv_state = ID_A;
            adv_bit   = id_a[10];
         end
         ID_A: begin
            if (cnt == 6'd10) begin
               adv_state = ide ? SRR : RTR;
               adv_bit   = ide ? 1'b1 : rtr;
            end else begin
               adv_state = ID_A;
               adv_cnt   = cnt + 6'd1;
               adv_bit   = id_a[4'd9 - cnt[3:0]];
            end
         end
         SRR: begin
            adv_state = IDE;
            adv_bit   = 1'b1;
         end
         IDE: begin
            adv_state = ide ? ID_B : R0;
            adv_bit   = ide ? id_b[17] : 1'b0;
         end
         ID_B: begin
            if (cnt == 6'd17) begin
               adv_state = RTR;
               adv_bit   = rtr;
            end else begin
               adv_state = ID_B;
               adv_cnt   = cnt + 6'd1;
               adv_bit   = id_b[5'd16 - cnt[4:0]];
            end
         end
         RTR: begin
            adv_state = ide ? R1 : IDE;
            adv_bit   = 1'b0;
         end
         R1: begin
            adv_state = R0;
            adv_bit   = 1'b0;
         end
         R0: begin
            adv_state = DLC;
            adv_bit   = dlc[3];
         end
         DLC: begin
            if (cnt == 6'd3) begin
               adv_state = (data_bits != 7'd0) ? DATA : CRC;
               adv_bit   = (data_bits != 7'd0) ? data[63] : crc[14];
            end else begin
               adv_state = DLC;
               adv_cnt   = cnt + 6'd1;
               adv_bit   = dlc[2'd2 - cnt[1:0]];
            end
         end
         DATA: begin
            if (data_last) begin
               adv_state = CRC;
               adv_bit   = crc[14];
            end else begin
               adv_state = DATA;
               adv_cnt   = cnt + 6'd1;
               adv_bit   = data[6'd62 - cnt];
            end
         end
         CRC: begin
            if (cnt == 6'd14) begin
               adv_state = CRC_DELIM;
            end else begin
               adv_state = CRC;
               adv_cnt   = cnt + 6'd1;
               adv_bit   = crc[4'd13 - cnt[3:0]];
            end
         end
         CRC_DELIM: adv_state = ACK_SLOT;
         ACK_SLOT:  adv_state = ACK_DELIM;
         ACK_DELIM: adv_state = EOF;
         EOF: begin
            if (cnt == 6'(EOF_BITS - 1)) begin
               adv_state = IFS;
            end else begin
               adv_state = EOF;
               adv_cnt   = cnt + 6'd1;
            end
         end
         IFS: begin
            adv_state = IFS;
            adv_cnt   = cnt + 6'd1;
         end
         default: adv_state = IDLE;
      endcase
   end

   // Bus readback at the sample instant; ARMED has not driven anything yet.
   always_comb begin
      lose_arb = 1'b0;
      ack_fail = 1'b0;
      bit_fail = 1'b0;
      if (rx_edge && tx_busy && (state != ARMED)) begin
         if (arb_field && tx_bit && !rx_bit) begin
            lose_arb = 1'b1;
         end else if (state == ACK_SLOT) begin
            ack_fail = rx_bit;
         end else if (tx_bit != rx_bit) begin
            bit_fail = 1'b1;
         end
      end
   end

   // Frame sequencer: latches fields on start, advances one bus bit per
   // transmit instant and aborts to IDLE on any readback error.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         cnt              <= 6'd0;
         sp_q             <= 1'b0;
         id_a             <= 11'd0;
         ide              <= 1'b0;
         id_b             <= 18'd0;
         rtr              <= 1'b0;
         dlc              <= 4'd0;
         data             <= 64'd0;
         crc              <= 15'd0;
         run_len          <= 3'd0;
         last_bit         <= 1'b1;
         stuff_bit        <= 1'b0;
         tx_bit           <= 1'b1;
         tx_busy          <= 1'b0;
         tx_done          <= 1'b0;
         arbitration_lost <= 1'b0;
         bit_error        <= 1'b0;
         ack_error        <= 1'b0;
      end else begin
         sp_q             <= sample_point;
         tx_done          <= 1'b0;
         arbitration_lost <= lose_arb;
         bit_error        <= bit_fail;
         ack_error        <= ack_fail;
         if (lose_arb || ack_fail || bit_fail) begin
            state     <= IDLE;
            tx_busy   <= 1'b0;
            tx_bit    <= 1'b1;
            stuff_bit <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (tx_start) begin
                     id_a      <= field_id_a;
                     ide       <= field_ide;
                     id_b      <= field_id_b;
                     rtr       <= field_rtr;
                     dlc       <= field_dlc;
                     data      <= field_data;
                     crc       <= 15'd0;
                     run_len   <= 3'd0;
                     last_bit  <= 1'b1;
                     stuff_bit <= 1'b0;
                     cnt       <= 6'd0;
                     tx_busy   <= 1'b1;
                     state     <= ARMED;
                  end
               end
               ARMED: begin
                  if (tx_edge) begin
                     state    <= SOF;
                     tx_bit   <= 1'b0;
                     run_len  <= 3'd1;
                     last_bit <= 1'b0;
                     crc      <= crc_step(15'd0, 1'b0);
                  end
               end
               default: begin
                  if (tx_edge) begin
                     if (do_stuff) begin
                        tx_bit    <= ~last_bit;
                        last_bit  <= ~last_bit;
                        run_len   <= 3'd1;
                        stuff_bit <= 1'b1;
                     end else if (frame_end) begin
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                        tx_bit  <= 1'b1;
                        tx_done <= 1'b1;
                     end else begin
                        state     <= adv_state;
                        cnt       <= adv_cnt;
                        tx_bit    <= adv_bit;
                        stuff_bit <= 1'b0;
                        // CRC goes through the stuff logic too; CRC_DELIM onward does not.
                        if (adv_state inside {ID_A, SRR, IDE, ID_B, RTR, R1, R0, DLC, DATA, CRC}) begin
                           run_len  <= (adv_bit == last_bit) ? run_len + 3'd1 : 3'd1;
                           last_bit <= adv_bit;
                        end
                        if (crc_zone) begin
                           crc <= crc_step(crc, adv_bit);
                        end
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_can_encoder.sv
// Directed bench for can_encoder: every bus bit is compared against a frame model
// that assembles, CRCs and stuffs each frame on its own, plus pulse/abort checks.
module tb_can_encoder;

   logic        clock = 1'b0;
   logic        reset;
   logic        sample_point;
   logic        rx_mask;
   logic        rx_bit;
   logic        tx_start;
   logic [10:0] field_id_a;
   logic        field_ide;
   logic [17:0] field_id_b;
   logic        field_rtr;
   logic [3:0]  field_dlc;
   logic [63:0] field_data;
   logic        tx_bit;
   logic        tx_busy;
   logic        tx_done;
   logic        arbitration_lost;
   logic        bit_error;
   logic        ack_error;

   int check_count = 0;
   int fail_count = 0;
   int done_seen = 0;
   int arb_seen = 0;
   int bit_err_seen = 0;
   int ack_err_seen = 0;
   int done_base;
   int arb_base;
   int bit_err_base;
   int ack_err_base;

   logic        exp_bits[$];
   int          raw_pos[$];
   int          ack_idx;
   logic        tail_stuff;
   logic [29:0] first30;
   logic [10:0] t4_id;

   localparam logic [63:0] T1_DATA = 64'h01A5_5A5A_5A5A_5A5A;

   can_encoder #(.EOF_BITS(7), .IFS_BITS(3)) dut (
      .clock(clock),
      .reset(reset),
      .sample_point(sample_point),
      .rx_bit(rx_bit),
      .tx_start(tx_start),
      .field_id_a(field_id_a),
      .field_ide(field_ide),
      .field_id_b(field_id_b),
      .field_rtr(field_rtr),
      .field_dlc(field_dlc),
      .field_data(field_data),
      .tx_bit(tx_bit),
      .tx_busy(tx_busy),
      .tx_done(tx_done),
      .arbitration_lost(arbitration_lost),
      .bit_error(bit_error),
      .ack_error(ack_error)
   );

   always #5 clock = ~clock;

   // The bus is a wired-AND of the DUT and whatever the bench pulls dominant.
   assign rx_bit = tx_bit & rx_mask;

   always @(negedge clock) begin
      if (tx_done) done_seen <= done_seen + 1;
      if (arbitration_lost) arb_seen <= arb_seen + 1;
      if (bit_error) bit_err_seen <= bit_err_seen + 1;
      if (ack_error) ack_err_seen <= ack_err_seen + 1;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      check_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic snapPulses();
      done_base    = done_seen;
      arb_base     = arb_seen;
      bit_err_base = bit_err_seen;
      ack_err_base = ack_err_seen;
   endtask

   task automatic buildFrame(input logic [10:0] id_a, input logic ide, input logic [17:0] id_b,
                             input logic rtr, input logic [3:0] dlc, input logic [63:0] data);
      logic        raw[$];
      logic [14:0] crc;
      logic        fb;
      logic        last;
      int          nbits;
      int          run;
      raw = {};
      raw.push_back(1'b0);
      for (int i = 10; i >= 0; i--) raw.push_back(id_a[i]);
      if (ide) begin
         raw.push_back(1'b1);
         raw.push_back(1'b1);
         for (int i = 17; i >= 0; i--) raw.push_back(id_b[i]);
         raw.push_back(rtr);
         raw.push_back(1'b0);
         raw.push_back(1'b0);
      end else begin
         raw.push_back(rtr);
         raw.push_back(1'b0);
         raw.push_back(1'b0);
      end
      for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
      nbits = rtr ? 0 : ((int'(dlc) > 8) ? 64 : int'(dlc) * 8);
      for (int i = 0; i < nbits; i++) raw.push_back(data[63 - i]);
      crc = 15'd0;
      foreach (raw[i]) begin
         fb  = raw[i] ^ crc[14];
         crc = {crc[13:0], 1'b0};
         if (fb) crc = crc ^ 15'h4599;
      end
      for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
      exp_bits   = {};
      raw_pos    = {};
      run        = 0;
      last       = 1'b1;
      tail_stuff = 1'b0;
      foreach (raw[i]) begin
         raw_pos.push_back(exp_bits.size());
         exp_bits.push_back(raw[i]);
         if (raw[i] == last) run++;
         else begin
            run  = 1;
            last = raw[i];
         end
         if (run == 5) begin
            exp_bits.push_back(!raw[i]);
            last = !raw[i];
            run  = 1;
            if (i == raw.size() - 1) tail_stuff = 1'b1;
         end
      end
      exp_bits.push_back(1'b1);
      ack_idx = exp_bits.size();
      exp_bits.push_back(1'b1);
      exp_bits.push_back(1'b1);
      for (int i = 0; i < 7 + 3; i++) exp_bits.push_back(1'b1);
   endtask

   task automatic applyStimulus(input logic [10:0] id_a, input logic ide, input logic [17:0] id_b,
                                input logic rtr, input logic [3:0] dlc, input logic [63:0] data);
      field_id_a = id_a;
      field_ide  = ide;
      field_id_b = id_b;
      field_rtr  = rtr;
      field_dlc  = dlc;
      field_data = data;
      tx_start   = 1'b1;
      @(negedge clock);
      tx_start   = 1'b0;
      @(negedge clock);
   endtask

   // One bit period: transmit instant, sample of tx_bit mid-bit, then the bus sample instant.
   task automatic runBit(input logic mask, output logic sampled);
      sample_point = 1'b0;
      repeat (2) @(negedge clock);
      sampled = tx_bit;
      rx_mask = mask;
      repeat (2) @(negedge clock);
      sample_point = 1'b1;
      repeat (4) @(negedge clock);
      rx_mask = 1'b1;
   endtask

   task automatic sendFrame(input string tag, input int from, input int upto, input logic use_ack, input int force_idx);
      logic b;
      logic bad;
      bad = 1'b0;
      for (int i = from; i < upto; i++) begin
         runBit(((use_ack && i == ack_idx) || i == force_idx) ? 1'b0 : 1'b1, b);
         if (i < 30) first30 = {first30[28:0], b};
         if (!bad) begin
            checkOutput($sformatf("%s_bit%0d", tag, i), 64'(b), 64'(exp_bits[i]));
            bad = (b !== exp_bits[i]);
         end
      end
   endtask

   task automatic endOfFrame(input string tag);
      logic b;
      checkOutput({tag, "_busy_in_ifs"}, 64'(tx_busy), 64'd1);
      checkOutput({tag, "_no_early_done"}, 64'(done_seen - done_base), 64'd0);
      runBit(1'b1, b);
      checkOutput({tag, "_done_pulses"}, 64'(done_seen - done_base), 64'd1);
      checkOutput({tag, "_busy_after"}, 64'(tx_busy), 64'd0);
      checkOutput({tag, "_tx_recessive"}, 64'(tx_bit), 64'd1);
      checkOutput({tag, "_no_errors"}, 64'(arb_seen - arb_base + bit_err_seen - bit_err_base + ack_err_seen - ack_err_base), 64'd0);
   endtask

   initial begin
      logic b;
      reset        = 1'b1;
      sample_point = 1'b1;
      rx_mask      = 1'b1;
      tx_start     = 1'b0;
      field_id_a   = 11'd0;
      field_ide    = 1'b0;
      field_id_b   = 18'd0;
      field_rtr    = 1'b0;
      field_dlc    = 4'd0;
      field_data   = 64'd0;
      first30      = 30'd0;
      t4_id        = 11'd0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("reset_tx_bit", 64'(tx_bit), 64'd1);
      checkOutput("reset_busy", 64'(tx_busy), 64'd0);
      checkOutput("reset_pulses", 64'({tx_done, arbitration_lost, bit_error, ack_error}), 64'd0);

      $display("[TB] test 1: standard frame with loopback and ACK");
      buildFrame(11'h014, 1'b0, 18'd0, 1'b0, 4'd1, T1_DATA);
      snapPulses();
      applyStimulus(11'h014, 1'b0, 18'd0, 1'b0, 4'd1, T1_DATA);
      checkOutput("t1_busy_armed", 64'(tx_busy), 64'd1);
      sendFrame("t1", 0, exp_bits.size(), 1'b1, -1);
      checkOutput("t1_first30", 64'(first30), 64'(30'b000001001010000010001000001001));
      endOfFrame("t1");

      $display("[TB] test 2: no ACK driver");
      snapPulses();
      applyStimulus(11'h014, 1'b0, 18'd0, 1'b0, 4'd1, T1_DATA);
      sendFrame("t2", 0, ack_idx + 1, 1'b0, -1);
      checkOutput("t2_ack_error", 64'(ack_err_seen - ack_err_base), 64'd1);
      checkOutput("t2_busy", 64'(tx_busy), 64'd0);
      checkOutput("t2_tx_bit", 64'(tx_bit), 64'd1);
      repeat (12) runBit(1'b1, b);
      checkOutput("t2_no_done", 64'(done_seen - done_base), 64'd0);
      checkOutput("t2_no_bit_error", 64'(bit_err_seen - bit_err_base), 64'd0);

      $display("[TB] test 3: extended frame loses arbitration in ID_B");
      buildFrame(11'h7FF, 1'b1, 18'h3FFFF, 1'b0, 4'd2, 64'h1234_0000_0000_0000);
      snapPulses();
      applyStimulus(11'h7FF, 1'b1, 18'h3FFFF, 1'b0, 4'd2, 64'h1234_0000_0000_0000);
      sendFrame("t3", 0, raw_pos[19] + 1, 1'b1, raw_pos[19]);
      checkOutput("t3_arb_lost", 64'(arb_seen - arb_base), 64'd1);
      checkOutput("t3_busy", 64'(tx_busy), 64'd0);
      checkOutput("t3_tx_bit", 64'(tx_bit), 64'd1);
      checkOutput("t3_no_bit_error", 64'(bit_err_seen - bit_err_base), 64'd0);
      repeat (4) runBit(1'b1, b);
      checkOutput("t3_stays_idle", 64'({tx_busy, tx_bit}), 64'b01);

      $display("[TB] test 4: remote frame with dlc=8 and a stuff bit after the CRC");
      for (int id = 0; id < 2048; id++) begin
         buildFrame(11'(id), 1'b0, 18'd0, 1'b1, 4'd8, 64'hFEDC_BA98_7654_3210);
         if (tail_stuff) begin
            t4_id = 11'(id);
            break;
         end
      end
      $display("[TB] test 4 uses id_a=0x%0h", t4_id);
      buildFrame(t4_id, 1'b0, 18'd0, 1'b1, 4'd8, 64'hFEDC_BA98_7654_3210);
      snapPulses();
      applyStimulus(t4_id, 1'b0, 18'd0, 1'b1, 4'd8, 64'hFEDC_BA98_7654_3210);
      sendFrame("t4", 0, exp_bits.size(), 1'b1, -1);
      endOfFrame("t4");

      $display("[TB] test 5: reset in the middle of DATA");
      buildFrame(11'h014, 1'b0, 18'd0, 1'b0, 4'd1, T1_DATA);
      snapPulses();
      applyStimulus(11'h014, 1'b0, 18'd0, 1'b0, 4'd1, T1_DATA);
      sendFrame("t5a", 0, 24, 1'b1, -1);
      sample_point = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("t5_dominant_before_reset", 64'(tx_bit), 64'd0);
      #1 reset = 1'b1;
      #1;
      checkOutput("t5_async_tx_bit", 64'(tx_bit), 64'd1);
      checkOutput("t5_async_busy", 64'(tx_busy), 64'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      sample_point = 1'b1;
      repeat (4) @(negedge clock);
      snapPulses();
      applyStimulus(11'h014, 1'b0, 18'd0, 1'b0, 4'd1, T1_DATA);
      sendFrame("t5b", 0, exp_bits.size(), 1'b1, -1);
      endOfFrame("t5b");

      $display("[TB] test 6: tx_start while busy is ignored");
      buildFrame(11'h014, 1'b0, 18'd0, 1'b0, 4'd1, T1_DATA);
      snapPulses();
      applyStimulus(11'h014, 1'b0, 18'd0, 1'b0, 4'd1, T1_DATA);
      sendFrame("t6a", 0, 10, 1'b1, -1);
      applyStimulus(11'h7FF, 1'b1, 18'h2AAAA, 1'b1, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF);
      sendFrame("t6b", 10, exp_bits.size(), 1'b1, -1);
      endOfFrame("t6");
      repeat (3) runBit(1'b1, b);
      checkOutput("t6_no_second_frame", 64'({tx_busy, tx_bit}), 64'b01);

      $display("[TB] test 7: dominant bus on CRC delimiter");
      snapPulses();
      applyStimulus(11'h014, 1'b0, 18'd0, 1'b0, 4'd1, T1_DATA);
      sendFrame("t7", 0, ack_idx, 1'b1, ack_idx - 1);
      checkOutput("t7_bit_error", 64'(bit_err_seen - bit_err_base), 64'd1);
      checkOutput("t7_busy", 64'(tx_busy), 64'd0);
      checkOutput("t7_no_other_pulse", 64'(arb_seen - arb_base + ack_err_seen - ack_err_base + done_seen - done_base), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule
